// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage controller: issues data-memory requests, stalls upstream
// stages while an access is outstanding, and loads the MEM/WB register.
module mem_stage_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  wb_i,
    input  logic [1:0]  m_i,
    input  logic [31:0] alu_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic [1:0]  wb_o,
    output logic [31:0] rdata_o,
    output logic [31:0] alu_o,
    output logic [4:0]  rd_o,
    output logic        err_o
);

    // Memory handshake: dmem_req_o and its address/data/we stay stable from the
    // edge that raises it until the edge on which dmem_ack_i (a one-cycle pulse)
    // is sampled high or the 16-cycle timeout fires; acks seen in IDLE are ignored.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       access;
    logic       misaligned;
    logic [1:0] wb_eff;

    assign access     = m_i[1] | m_i[0];
    assign misaligned = (alu_i[1:0] != 2'b00);
    // A combined read+write performs the write and suppresses writeback.
    assign wb_eff     = (m_i == 2'b11) ? 2'b00 : wb_i;

    // Stall drops in the final timeout cycle so the pipeline advances on that edge.
    assign stall_o = rst_i &&
                     (((state == S_IDLE) && access && !misaligned) ||
                      ((state == S_WAIT) && !dmem_ack_i && (cnt != 4'hF)));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= S_IDLE;
            cnt          <= 4'h0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= 32'h0;
            dmem_wdata_o <= 32'h0;
            wb_o         <= 2'b00;
            rdata_o      <= 32'h0;
            alu_o        <= 32'h0;
            rd_o         <= 5'h0;
            err_o        <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    alu_o   <= alu_i;
                    rd_o    <= rd_i;
                    rdata_o <= 32'h0;
                    if (access && !misaligned) begin
                        state        <= S_WAIT;
                        cnt          <= 4'h0;
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= m_i[0];
                        dmem_addr_o  <= alu_i;
                        dmem_wdata_o <= wdata_i;
                        wb_o         <= 2'b00;
                    end else if (access) begin
                        wb_o  <= 2'b00;
                        err_o <= 1'b1;
                    end else begin
                        wb_o <= wb_i;
                    end
                end
                S_WAIT: begin
                    alu_o <= alu_i;
                    rd_o  <= rd_i;
                    if (dmem_ack_i) begin
                        state      <= S_IDLE;
                        dmem_req_o <= 1'b0;
                        wb_o       <= wb_eff;
                        rdata_o    <= dmem_we_o ? 32'h0 : dmem_rdata_i;
                    end else if (cnt == 4'hF) begin
                        state      <= S_IDLE;
                        dmem_req_o <= 1'b0;
                        wb_o       <= 2'b00;
                        rdata_o    <= 32'h0;
                        err_o      <= 1'b1;
                    end else begin
                        cnt     <= cnt + 4'h1;
                        wb_o    <= 2'b00;
                        rdata_o <= 32'h0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed cases plus a random mix,
// with expected MEM/WB results queued at stimulus time and popped at completion.
module tb_mem_stage_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  wb_i;
    logic [1:0]  m_i;
    logic [31:0] alu_i;
    logic [31:0] wdata_i;
    logic [4:0]  rd_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_o;
    logic [1:0]  wb_o;
    logic [31:0] rdata_o;
    logic [31:0] alu_o;
    logic [4:0]  rd_o;
    logic        err_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [71:0] exp_q[$];

    mem_stage_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .wb_i(wb_i), .m_i(m_i), .alu_i(alu_i),
        .wdata_i(wdata_i), .rd_i(rd_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i),
        .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o), .wb_o(wb_o), .rdata_o(rdata_o),
        .alu_o(alu_o), .rd_o(rd_o), .err_o(err_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] pack(input logic [1:0] wb, input logic [31:0] alu,
                                         input logic [4:0] rd, input logic [31:0] rdata,
                                         input logic err);
        return {wb, alu, rd, rdata, err};
    endfunction

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // scoreboard: pop the oldest expected MEM/WB result and compare
    task automatic sb_compare(input string tag);
        logic [71:0] exp;
        if (exp_q.size() == 0) begin
            check({tag, "_empty_q"}, 72'h1, 72'h0);
        end else begin
            exp = exp_q.pop_front();
            check(tag, pack(wb_o, alu_o, rd_o, rdata_o, err_o), exp);
        end
    endtask

    // driver: one EX/MEM instruction; ack_wait<0 means the memory never acks
    task automatic do_op(input string tag, input logic [1:0] wb, input logic [1:0] m,
                         input logic [31:0] alu, input logic [31:0] wdata,
                         input logic [4:0] rd, input int ack_wait, input logic [31:0] rdata);
        logic acc;
        logic mis;
        logic done;
        acc = m[1] | m[0];
        mis = (alu[1:0] != 2'b00);
        wb_i = wb; m_i = m; alu_i = alu; wdata_i = wdata; rd_i = rd;
        dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
        if (!acc || mis) begin
            exp_q.push_back(pack((acc && mis) ? 2'b00 : wb, alu, rd, 32'h0, acc && mis));
            #1 check({tag, "_stall"}, {71'h0, stall_o}, 72'h0);
            step();
            check({tag, "_noreq"}, {71'h0, dmem_req_o}, 72'h0);
            sb_compare({tag, "_mw"});
        end else begin
            if (ack_wait < 0)
                exp_q.push_back(pack(2'b00, alu, rd, 32'h0, 1'b1));
            else
                exp_q.push_back(pack((m == 2'b11) ? 2'b00 : wb, alu, rd,
                                     m[0] ? 32'h0 : rdata, 1'b0));
            #1 check({tag, "_stall_idle"}, {71'h0, stall_o}, 72'h1);
            step();
            check({tag, "_req"}, {69'h0, dmem_req_o, dmem_we_o, err_o}, {69'h0, 1'b1, m[0], 1'b0});
            check({tag, "_addr"}, {8'h0, dmem_addr_o, dmem_wdata_o}, {8'h0, alu, wdata});
            check({tag, "_bubble"}, {70'h0, wb_o}, 72'h0);
            done = 1'b0;
            for (int i = 0; i < 16 && !done; i++) begin
                if (i == ack_wait) begin
                    dmem_ack_i = 1'b1; dmem_rdata_i = rdata;
                    #1 check({tag, "_stall_ack"}, {71'h0, stall_o}, 72'h0);
                    step();
                    dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
                    done = 1'b1;
                end else if (i == 15) begin
                    #1 check({tag, "_stall_to"}, {71'h0, stall_o}, 72'h0);
                    step();
                    done = 1'b1;
                end else begin
                    #1 check({tag, "_stall_wait"}, {71'h0, stall_o}, 72'h1);
                    step();
                    check({tag, "_hold"}, {6'h0, dmem_req_o, dmem_we_o, dmem_addr_o, wb_o, err_o, 30'h0},
                          {6'h0, 1'b1, m[0], alu, 2'b00, 1'b0, 30'h0});
                end
            end
            check({tag, "_req_drop"}, {71'h0, dmem_req_o}, 72'h0);
            sb_compare({tag, "_mw"});
        end
    endtask

    initial begin
        logic [31:0] r_alu;
        logic [31:0] r_dat;
        logic [31:0] r_rd;
        int kind;
        rst_i = 1'b0; wb_i = 2'b00; m_i = 2'b00; alu_i = 32'h0; wdata_i = 32'h0;
        rd_i = 5'h0; dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
        repeat (3) @(negedge clk_i);
        check("rst_ctl", {68'h0, dmem_req_o, dmem_we_o, err_o, stall_o}, 72'h0);
        check("rst_bus", {8'h0, dmem_addr_o, dmem_wdata_o}, 72'h0);
        check("rst_mw", pack(wb_o, alu_o, rd_o, rdata_o, err_o), 72'h0);
        rst_i = 1'b1;

        do_op("alu", 2'b10, 2'b00, 32'h40, 32'h0, 5'd5, 0, 32'h0);
        do_op("load3", 2'b11, 2'b10, 32'h100, 32'h0, 5'd7, 3, 32'hDEADBEEF);
        do_op("store0", 2'b00, 2'b01, 32'h200, 32'h12345678, 5'd0, 0, 32'hFFFF0000);
        do_op("both", 2'b11, 2'b11, 32'h204, 32'hCAFEF00D, 5'd9, 1, 32'h55AA55AA);
        do_op("misal", 2'b11, 2'b10, 32'h102, 32'h0, 5'd3, 0, 32'h0);
        do_op("after_err", 2'b10, 2'b00, 32'h7, 32'h0, 5'd4, 0, 32'h0);
        do_op("timeout", 2'b11, 2'b10, 32'h300, 32'h0, 5'd6, -1, 32'h0);
        do_op("ack15", 2'b11, 2'b10, 32'h304, 32'h0, 5'd8, 15, 32'h0BADCAFE);

        // ack in IDLE has no effect
        wb_i = 2'b10; m_i = 2'b00; alu_i = 32'h44; rd_i = 5'd2;
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'h99999999;
        #1 check("idle_ack_stall", {71'h0, stall_o}, 72'h0);
        step();
        dmem_ack_i = 1'b0;
        check("idle_ack", pack(wb_o, alu_o, rd_o, rdata_o, err_o), pack(2'b10, 32'h44, 5'd2, 32'h0, 1'b0));
        check("idle_ack_req", {71'h0, dmem_req_o}, 72'h0);

        // reset while a request is outstanding
        wb_i = 2'b11; m_i = 2'b10; alu_i = 32'h400; rd_i = 5'd1;
        step();
        check("mid_req", {71'h0, dmem_req_o}, 72'h1);
        #2 rst_i = 1'b0;
        #1 check("mid_rst_ctl", {68'h0, dmem_req_o, dmem_we_o, err_o, stall_o}, 72'h0);
        check("mid_rst_bus", {8'h0, dmem_addr_o, dmem_wdata_o}, 72'h0);
        check("mid_rst_mw", pack(wb_o, alu_o, rd_o, rdata_o, err_o), 72'h0);
        @(negedge clk_i);
        wb_i = 2'b00; m_i = 2'b00; alu_i = 32'h0; rd_i = 5'd0;
        rst_i = 1'b1;
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'h77777777;
        step();
        dmem_ack_i = 1'b0;
        check("late_ack", {5'h0, dmem_req_o, err_o, wb_o, rdata_o, 32'h0}, 72'h0);

        // random mix
        for (int n = 0; n < 24; n++) begin
            kind = $urandom_range(0, 3);
            r_alu = $urandom; r_dat = $urandom; r_rd = $urandom;
            case (kind)
                0: do_op("r_alu", 2'($urandom_range(0, 3)), 2'b00, r_alu, r_dat, r_rd[4:0], 0, 32'h0);
                1: do_op("r_load", 2'b11, 2'b10, {r_alu[31:2], 2'b00}, r_dat, r_rd[4:0],
                         $urandom_range(0, 5), r_dat ^ 32'hA5A5A5A5);
                2: do_op("r_store", 2'b00, 2'b01, {r_alu[31:2], 2'b00}, r_dat, r_rd[4:0],
                         $urandom_range(0, 5), r_dat);
                default: do_op("r_misal", 2'b11, 2'($urandom_range(1, 3)),
                               {r_alu[31:2], 2'($urandom_range(1, 3))}, r_dat, r_rd[4:0], 0, 32'h0);
            endcase
        end

        check("q_drained", 72'(exp_q.size()), 72'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
